// File: rtl/button_conditioner.sv
// Per-channel 2-FF synchroniser plus counting debouncer for the player push-buttons.
// Emits registered debounced levels and one-cycle press/release strobes.
module button_conditioner #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] buttons,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_o,
    output logic             any_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic             s1_q, s2_q;
        logic             stable_q, stable_d;
        logic             press_q, press_d;
        logic             rel_q, rel_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Accept a change only after s2 has disagreed with stable for CNT_MAX+1 edges.
        always_comb begin
            stable_d = stable_q;
            cnt_d    = cnt_q;
            press_d  = 1'b0;
            rel_d    = 1'b0;
            if (s2_q == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                stable_d = s2_q;
                cnt_d    = '0;
                press_d  = s2_q;
                rel_d    = ~s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q     <= 1'b0;
                s2_q     <= 1'b0;
                stable_q <= 1'b0;
                cnt_q    <= '0;
                press_q  <= 1'b0;
                rel_q    <= 1'b0;
            end else begin
                s1_q     <= btn_raw[i];
                s2_q     <= s1_q;
                stable_q <= stable_d;
                cnt_q    <= cnt_d;
                press_q  <= press_d;
                rel_q    <= rel_d;
            end
        end

        assign buttons[i]   = stable_q;
        assign press[i]     = press_q;
        assign release_o[i] = rel_q;
    end

    assign any_press = |press;

endmodule
